// File: rtl/project_tri.sv
// project_tri: perspective projection of one triangle of camera-relative
// vertices to screen space. Near-plane culling is followed by six restoring
// divides (v1.x, v1.y, v2.x, v2.y, v3.x, v3.y) on one shared divider.
module project_tri #(
  parameter int FOCAL_SHIFT = 7,
  parameter int X_CENTER    = 512,
  parameter int Y_CENTER    = 384
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic signed [2:0][7:0] v1_in,
  input  logic signed [2:0][7:0] v2_in,
  input  logic signed [2:0][7:0] v3_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic [1:0][11:0]       p1_out,
  output logic [1:0][11:0]       p2_out,
  output logic [1:0][11:0]       p3_out,
  output logic                   culled_out,
  output logic                   valid_out,
  input  logic                   ready_in
);

  // |c| is at most 128, so the numerator needs 8 + FOCAL_SHIFT bits and the
  // divider retires one quotient bit per cycle over that many cycles.
  localparam int NUM_W  = 8 + FOCAL_SHIFT;
  localparam int ITER_W = $clog2(NUM_W + 1);

  typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;
  state_t state_q, state_d;

  // Captured triangle: vtx_q[vertex][axis], axis 0=x 1=y 2=z.
  logic [2:0][2:0][7:0] vtx_q;

  // Divider job/iteration control and datapath.
  logic [2:0]        job_q;
  logic [ITER_W-1:0] iter_q;
  logic [NUM_W-1:0]  num_q;
  logic [NUM_W-2:0]  quo_q;
  logic [6:0]        rem_q;
  logic [6:0]        div_q;
  logic              neg_q;

  // Result registers.
  logic                 culled_q;
  logic [2:0][1:0][11:0] pr_q;

  logic              cull;
  logic              last_iter;
  logic              last_job;
  logic              load_en;
  logic [2:0]        ld_job;
  logic signed [7:0] ld_c;
  logic [6:0]        ld_z;
  logic [7:0]        ld_abs;
  logic [7:0]        rem_sh;
  logic [6:0]        rem_sub;
  logic              ge;
  logic [NUM_W-1:0]  quo_nx;
  logic signed [11:0] q_sat;
  logic signed [11:0] coord;

  // Clamp the signed quotient (magnitude + sign) to [-1024, 1023].
  function automatic logic signed [11:0] sat_q(input logic [NUM_W-1:0] mag,
                                               input logic neg);
    logic signed [11:0] r;
    if (!neg) begin
      r = (mag > NUM_W'(1023)) ? 12'sd1023 : $signed({1'b0, mag[10:0]});
    end else begin
      r = (mag > NUM_W'(1024)) ? -12'sd1024 : -$signed({1'b0, mag[10:0]});
    end
    return r;
  endfunction

  // Screen y grows downward, so y subtracts the quotient.
  function automatic logic signed [11:0] to_screen(input logic signed [11:0] q,
                                                   input logic axis);
    return axis ? (12'(Y_CENTER) - q) : (12'(X_CENTER) + q);
  endfunction

  assign cull = ($signed(vtx_q[0][2]) <= 8'sd0) ||
                ($signed(vtx_q[1][2]) <= 8'sd0) ||
                ($signed(vtx_q[2][2]) <= 8'sd0);

  assign last_iter = (iter_q == ITER_W'(NUM_W - 1));
  assign last_job  = (job_q == 3'd5);
  assign load_en   = ((state_q == CHECK) && !cull) ||
                     ((state_q == DIV) && last_iter && !last_job);

  assign rem_sh  = {rem_q, num_q[NUM_W-1]};
  assign ge      = (rem_sh >= {1'b0, div_q});
  assign rem_sub = 7'(rem_sh - {1'b0, div_q});
  assign quo_nx  = {quo_q, ge};
  assign q_sat   = sat_q(quo_nx, neg_q);
  assign coord   = to_screen(q_sat, job_q[0]);

  // Select the operand pair for the job that loads next.
  always_comb begin
    ld_job = (state_q == CHECK) ? 3'd0 : job_q + 3'd1;
    ld_c   = '0;
    ld_z   = '0;
    case (ld_job)
      3'd0: begin ld_c = vtx_q[0][0]; ld_z = vtx_q[0][2][6:0]; end
      3'd1: begin ld_c = vtx_q[0][1]; ld_z = vtx_q[0][2][6:0]; end
      3'd2: begin ld_c = vtx_q[1][0]; ld_z = vtx_q[1][2][6:0]; end
      3'd3: begin ld_c = vtx_q[1][1]; ld_z = vtx_q[1][2][6:0]; end
      3'd4: begin ld_c = vtx_q[2][0]; ld_z = vtx_q[2][2][6:0]; end
      default: begin ld_c = vtx_q[2][1]; ld_z = vtx_q[2][2][6:0]; end
    endcase
    ld_abs = ld_c[7] ? 8'(-ld_c) : ld_c;
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_in) state_d = CHECK;
      CHECK:   state_d = cull ? DONE : DIV;
      DIV:     if (last_iter && last_job) state_d = DONE;
      DONE:    if (ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Input capture and divider datapath; contents are don't-care outside a job.
  always_ff @(posedge clk_in) begin
    if ((state_q == IDLE) && valid_in) begin
      vtx_q[0] <= v1_in;
      vtx_q[1] <= v2_in;
      vtx_q[2] <= v3_in;
    end
    if (load_en) begin
      num_q <= {ld_abs, {FOCAL_SHIFT{1'b0}}};
      div_q <= ld_z;
      neg_q <= ld_c[7];
      rem_q <= '0;
      quo_q <= '0;
    end else if (state_q == DIV) begin
      num_q <= num_q << 1;
      rem_q <= ge ? rem_sub : rem_sh[6:0];
      quo_q <= quo_nx[NUM_W-2:0];
    end
  end

  // Job sequencing and result registers; reset clears every visible output.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      job_q    <= '0;
      iter_q   <= '0;
      culled_q <= 1'b0;
      pr_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            culled_q <= 1'b0;
            pr_q     <= '0;
          end
        end
        CHECK: begin
          job_q  <= '0;
          iter_q <= '0;
          if (cull) culled_q <= 1'b1;
        end
        DIV: begin
          if (last_iter) begin
            pr_q[job_q[2:1]][job_q[0]] <= coord;
            job_q  <= job_q + 3'd1;
            iter_q <= '0;
          end else begin
            iter_q <= iter_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_out  = (state_q == IDLE);
  assign valid_out  = (state_q == DONE);
  assign culled_out = culled_q;
  assign p1_out     = pr_q[0];
  assign p2_out     = pr_q[1];
  assign p3_out     = pr_q[2];

endmodule

// File: tb/tb_project_tri.sv
// Bench for project_tri: directed and random triangles against an
// arithmetic projection model, plus backpressure, busy and reset cases.
module tb_project_tri;

  localparam int FS = 7;
  localparam int XC = 512;
  localparam int YC = 384;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic signed [2:0][7:0] v1, v2, v3;
  logic                   valid_in, ready_out, culled_out, valid_out, ready_in;
  logic [1:0][11:0]       p1, p2, p3;

  int errors = 0;
  int checks = 0;
  int tv[3][3];
  int exp_p[3][2];
  int exp_cull;

  project_tri #(.FOCAL_SHIFT(FS), .X_CENTER(XC), .Y_CENTER(YC)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .v1_in(v1), .v2_in(v2), .v3_in(v3),
    .valid_in(valid_in), .ready_out(ready_out),
    .p1_out(p1), .p2_out(p2), .p3_out(p3),
    .culled_out(culled_out), .valid_out(valid_out), .ready_in(ready_in)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Projection of one coordinate: truncating division, then clamp.
  function automatic int proj(input int c, input int z);
    int q;
    q = (c * (1 << FS)) / z;
    if (q > 1023)  q = 1023;
    if (q < -1024) q = -1024;
    return q;
  endfunction

  function automatic int get_p(input int v, input int a);
    logic [11:0] r;
    case (v)
      0:       r = p1[a];
      1:       r = p2[a];
      default: r = p3[a];
    endcase
    return int'($signed(r));
  endfunction

  task automatic set_tri(input int a0, input int a1, input int a2,
                         input int b0, input int b1, input int b2,
                         input int c0, input int c1, input int c2);
    tv[0][0] = a0; tv[0][1] = a1; tv[0][2] = a2;
    tv[1][0] = b0; tv[1][1] = b1; tv[1][2] = b2;
    tv[2][0] = c0; tv[2][1] = c1; tv[2][2] = c2;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_culled"}, int'(culled_out), exp_cull);
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 2; a++)
        check($sformatf("%s_p%0d%s", tag, v + 1, (a == 0) ? "x" : "y"),
              get_p(v, a), exp_p[v][a]);
  endtask

  // Send one triangle; optionally stall the result, pulse valid_in while
  // busy, or abort with reset at a given cycle after accept.
  task automatic run_tri(input string tag, input int hold,
                         input int pulse_at, input int abort_at);
    int cyc;
    exp_cull = 0;
    for (int v = 0; v < 3; v++) if (tv[v][2] <= 0) exp_cull = 1;
    for (int v = 0; v < 3; v++) begin
      exp_p[v][0] = exp_cull ? 0 : XC + proj(tv[v][0], tv[v][2]);
      exp_p[v][1] = exp_cull ? 0 : YC - proj(tv[v][1], tv[v][2]);
    end

    @(negedge clk);
    ready_in = (hold == 0);
    check({tag, "_ready_idle"}, int'(ready_out), 1);
    for (int k = 0; k < 3; k++) begin
      v1[k] = 8'(tv[0][k]);
      v2[k] = 8'(tv[1][k]);
      v3[k] = 8'(tv[2][k]);
    end
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    v1 = 24'($urandom); v2 = 24'($urandom); v3 = 24'($urandom);
    cyc = 0;
    check({tag, "_ready_busy"}, int'(ready_out), 0);

    while (!valid_out && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_valid"}, int'(valid_out), 0);
        check({tag, "_rst_culled"}, int'(culled_out), 0);
        check({tag, "_rst_ready"}, int'(ready_out), 1);
        for (int v = 0; v < 3; v++)
          for (int a = 0; a < 2; a++)
            check($sformatf("%s_rst_p%0d%0d", tag, v + 1, a), get_p(v, a), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (cyc == pulse_at) begin
        valid_in = 1'b1;
        v1 = 24'($urandom); v2 = 24'($urandom); v3 = 24'($urandom);
      end else begin
        valid_in = 1'b0;
      end
    end

    check({tag, "_latency"}, cyc, exp_cull ? 1 : 91);
    check({tag, "_ready_done"}, int'(ready_out), 0);
    check_outputs(tag);

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, int'(valid_out), 1);
      check({tag, "_hold_ready"}, int'(ready_out), 0);
      check_outputs({tag, "_hold"});
    end
    ready_in = 1'b1;

    @(posedge clk); #1;
    check({tag, "_taken_valid"}, int'(valid_out), 0);
    check({tag, "_taken_ready"}, int'(ready_out), 1);
  endtask

  initial begin
    v1 = '0; v2 = '0; v3 = '0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_ready", int'(ready_out), 1);
    check("reset_valid", int'(valid_out), 0);
    check("reset_culled", int'(culled_out), 0);
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 2; a++)
        check($sformatf("reset_p%0d%0d", v + 1, a), get_p(v, a), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    set_tri(10, 20, 64, -10, 0, 32, 0, 0, 1);
    run_tri("basic", 0, -1, -1);

    set_tri(10, 20, 64, -10, 0, 32, 127, -5, 1);
    run_tri("sat", 0, -1, -1);

    set_tri(7, 0, 3, -7, 0, 3, 1, 1, 1);
    run_tri("trunc", 0, -1, -1);

    set_tri(-128, -128, 1, 127, 127, 127, -1, 1, 127);
    run_tri("extreme", 0, -1, -1);

    set_tri(10, 20, 64, 5, 5, 0, 1, 1, 1);
    run_tri("cull_z0", 0, -1, -1);

    set_tri(10, 20, -1, 5, 5, 9, 1, 1, 1);
    run_tri("cull_zneg", 0, -1, -1);

    set_tri(33, -44, 50, -90, 17, 100, 2, -3, 5);
    run_tri("stall", 20, -1, -1);

    set_tri(-5, 60, 9, 12, -12, 12, 100, 100, 120);
    run_tri("after_stall", 0, 30, -1);

    set_tri(1, 2, 3, 4, 5, 6, 7, 8, 9);
    run_tri("abort", 0, -1, 41);

    set_tri(-20, 30, 40, 50, -60, 70, 80, 90, 100);
    run_tri("post_reset", 0, -1, -1);

    for (int i = 0; i < 6; i++) begin
      for (int v = 0; v < 3; v++) begin
        tv[v][0] = int'($urandom_range(255)) - 128;
        tv[v][1] = int'($urandom_range(255)) - 128;
        tv[v][2] = (i < 4) ? int'($urandom_range(127, 1))
                           : int'($urandom_range(255)) - 128;
      end
      run_tri($sformatf("rand%0d", i), (i == 2) ? 3 : 0, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
